dmem_responder: RTL

//  Data-memory responder for the pipeline's load/store path: the memory end of the
//  MEM-stage request interface. Accepts one word-addressed read/write request at a

---
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder.sv | 97 +++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Request/response channel between the MEM stage (master) and the data-memory
// responder (slave).
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with byte-enabled stores and a fixed
// response latency. Define DMEM_ERR_EN to flag misaligned/out-of-range accesses.
module dmem_responder #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 1
) (
   input logic           clk,
   input logic           reset,
   dmem_responder_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   mem [DEPTH];
   logic          accept;
   logic          handshake;
   logic          err;
   logic [AW-1:0] idx;

   always_comb begin
      accept    = bus.req_valid && bus.req_ready && !reset;
      handshake = bus.rsp_valid && bus.rsp_ready;
      idx       = bus.req_addr[2 +: AW];
`ifdef DMEM_ERR_EN
      err = (bus.req_addr[1:0] != 2'b00) || ((bus.req_addr >> 2) >= DEPTH);
`else
      err = 1'b0;
`endif
   end

   // Store commits on the accept edge so a following load always sees it.
   always_ff @(posedge clk) begin
      if (accept && bus.req_we && !err) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (bus.req_be[i])
               mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
`ifdef DMEM_ERR_EN
         bus.rsp_err   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  bus.req_ready <= 1'b0;
                  bus.rsp_rdata <= (bus.req_we || err) ? '0 : mem[idx];
`ifdef DMEM_ERR_EN
                  bus.rsp_err   <= err;
`endif
                  if (LATENCY == 1) begin
                     state         <= RESP;
                     bus.rsp_valid <= 1'b1;
                  end else begin
                     state <= WAIT;
                     cnt   <= CW'(LATENCY - 2);
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state         <= RESP;
                  bus.rsp_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               // No accept in this cycle: req_ready returns one cycle after handshake.
               if (handshake) begin
                  state         <= IDLE;
                  bus.rsp_valid <= 1'b0;
                  bus.req_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef DMEM_ERR_EN
   assign bus.rsp_err = 1'b0;
`endif
endmodule
